obj_report: RTL and testbench

Downstream consumer of the labeling/detection pipeline's per-object statistics port. After each frame, it walks every assigned label by driving `obj_id` and waiting out the statistics read latency. It captures the area and coordinate sums for each label, drops objects below a programmable minimum area, and streams the surviving records out over a valid/ready interface toward the host/bus side.

---
 rtl/obj_report.sv | 191 +++++++++++++++++++
 tb/tb_obj_report.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_report.sv
// Per-frame object report walker: scans labels 1..num_labels, waits out the stats read latency, and streams kept records.
// Optional area filter compiled in with `define OBJ_REPORT_FILTER_EN (default build reports every label).
module obj_report #(
  parameter int LBL_W  = 8,
  parameter int LOC_W  = 32,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_done,
  input  logic [LBL_W-1:0] num_labels,
  input  logic [LOC_W-1:0] min_area,
  output logic [LBL_W-1:0] obj_id,
  input  logic [LOC_W-1:0] obj_area,
  input  logic [LOC_W-1:0] obj_x,
  input  logic [LOC_W-1:0] obj_y,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [LBL_W-1:0] rpt_id,
  output logic [LOC_W-1:0] rpt_area,
  output logic [LOC_W-1:0] rpt_x,
  output logic [LOC_W-1:0] rpt_y,
  output logic             busy,
  output logic             done,
  output logic [LBL_W-1:0] rpt_count,
  output logic             overrun,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_SEND  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [3:0]       WAIT_INIT = 4'(RD_LAT - 1);
  localparam logic [LBL_W-1:0] LBL_MAX   = {LBL_W{1'b1}};

  // Handshake: a record transfers on a rising edge where rpt_valid && rpt_ready;
  // once rpt_valid rises, it and rpt_id/area/x/y stay unchanged until that transfer.

  state_t           state_q, state_d;
  logic [LBL_W-1:0] obj_id_q, obj_id_d;
  logic [LBL_W-1:0] last_lbl_q, last_lbl_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [LBL_W-1:0] rpt_id_q, rpt_id_d;
  logic [LOC_W-1:0] rpt_area_q, rpt_area_d;
  logic [LOC_W-1:0] rpt_x_q, rpt_x_d;
  logic [LOC_W-1:0] rpt_y_q, rpt_y_d;
  logic [LBL_W-1:0] rpt_count_q, rpt_count_d;
  logic             rpt_valid_q, rpt_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             area_pass;
  logic             last_hit;

`ifdef OBJ_REPORT_FILTER_EN
  assign area_pass = (rpt_area_q >= min_area);
`else
  logic unused_min_area;
  assign unused_min_area = ^min_area;
  assign area_pass       = 1'b1;
`endif

  // Compare against the latched count so num_labels may change mid-scan.
  assign last_hit = (obj_id_q == last_lbl_q);

  always_comb begin
    state_d     = state_q;
    obj_id_d    = obj_id_q;
    last_lbl_d  = last_lbl_q;
    wait_cnt_d  = wait_cnt_q;
    rpt_id_d    = rpt_id_q;
    rpt_area_d  = rpt_area_q;
    rpt_x_d     = rpt_x_q;
    rpt_y_d     = rpt_y_q;
    rpt_count_d = rpt_count_q;

    case (state_q)
      S_IDLE: begin
        if (frame_done) begin
          last_lbl_d  = num_labels;
          rpt_count_d = '0;
          if (num_labels == '0) begin
            state_d = S_DONE;
          end else begin
            obj_id_d = LBL_W'(1);
            state_d  = S_SET;
          end
        end
      end
      S_SET: begin
        wait_cnt_d = WAIT_INIT;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          rpt_id_d   = obj_id_q;
          rpt_area_d = obj_area;
          rpt_x_d    = obj_x;
          rpt_y_d    = obj_y;
          state_d    = S_CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      S_CHECK: begin
        if (area_pass) begin
          state_d = S_SEND;
        end else if (last_hit) begin
          state_d = S_DONE;
        end else begin
          obj_id_d = obj_id_q + 1'b1;
          state_d  = S_SET;
        end
      end
      S_SEND: begin
        if (rpt_ready) begin
          if (rpt_count_q != LBL_MAX) rpt_count_d = rpt_count_q + 1'b1;
          if (last_hit) begin
            state_d = S_DONE;
          end else begin
            obj_id_d = obj_id_q + 1'b1;
            state_d  = S_SET;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    rpt_valid_d = (state_d == S_SEND);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    overrun_d   = overrun_q | (frame_done && (state_q != S_IDLE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      obj_id_q    <= '0;
      last_lbl_q  <= '0;
      wait_cnt_q  <= '0;
      rpt_id_q    <= '0;
      rpt_area_q  <= '0;
      rpt_x_q     <= '0;
      rpt_y_q     <= '0;
      rpt_count_q <= '0;
      rpt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      obj_id_q    <= obj_id_d;
      last_lbl_q  <= last_lbl_d;
      wait_cnt_q  <= wait_cnt_d;
      rpt_id_q    <= rpt_id_d;
      rpt_area_q  <= rpt_area_d;
      rpt_x_q     <= rpt_x_d;
      rpt_y_q     <= rpt_y_d;
      rpt_count_q <= rpt_count_d;
      rpt_valid_q <= rpt_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign obj_id    = obj_id_q;
  assign rpt_valid = rpt_valid_q;
  assign rpt_id    = rpt_id_q;
  assign rpt_area  = rpt_area_q;
  assign rpt_x     = rpt_x_q;
  assign rpt_y     = rpt_y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rpt_count = rpt_count_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_obj_report.sv
// Bench for obj_report: a latency-accurate stats memory model, a record-level scan model, and per-scenario checks.
module tb_obj_report;
  localparam int LBL_W  = 8;
  localparam int LOC_W  = 32;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic [LBL_W-1:0] id;
    logic [LOC_W-1:0] area;
    logic [LOC_W-1:0] x;
    logic [LOC_W-1:0] y;
  } rec_t;

  logic             clk, reset, frame_done, rpt_valid, rpt_ready, busy, done, overrun;
  logic [LBL_W-1:0] num_labels, obj_id, rpt_id, rpt_count;
  logic [LOC_W-1:0] min_area, obj_area, obj_x, obj_y, rpt_area, rpt_x, rpt_y;
  logic [2:0]       dbg_state;

  logic [LOC_W-1:0] area_mem [256];
  logic [LOC_W-1:0] x_mem    [256];
  logic [LOC_W-1:0] y_mem    [256];
  logic [LBL_W-1:0] id_pipe  [RD_LAT];

  int   checks = 0;
  int   failures = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];
  int   sc_done_at, sc_busy, sc_done_cnt, sc_valid, sc_stall;
  bit   sc_timeout, sc_hold_bad, sc_idle_after;

  obj_report #(.LBL_W(LBL_W), .LOC_W(LOC_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .frame_done(frame_done), .num_labels(num_labels),
    .min_area(min_area), .obj_id(obj_id), .obj_area(obj_area), .obj_x(obj_x), .obj_y(obj_y),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_id(rpt_id), .rpt_area(rpt_area),
    .rpt_x(rpt_x), .rpt_y(rpt_y), .busy(busy), .done(done), .rpt_count(rpt_count),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stats memory: data for a selected label becomes visible RD_LAT edges after obj_id changes.
  always @(posedge clk) begin
    id_pipe[0] <= obj_id;
    for (int i = 1; i < RD_LAT; i++) id_pipe[i] <= id_pipe[i-1];
  end
  assign obj_area = area_mem[id_pipe[RD_LAT-1]];
  assign obj_x    = x_mem[id_pipe[RD_LAT-1]];
  assign obj_y    = y_mem[id_pipe[RD_LAT-1]];

  // Reference model: list of kept records and the sample index at which done should appear.
  function automatic int model_scan(input int n);
    int  cyc;
    bit  keep;
    cyc = 0;
    exp_q.delete();
    for (int l = 1; l <= n; l++) begin
`ifdef OBJ_REPORT_FILTER_EN
      keep = (area_mem[l] >= min_area);
`else
      keep = 1'b1;
`endif
      if (keep) begin
        exp_q.push_back({LBL_W'(l), area_mem[l], x_mem[l], y_mem[l]});
        cyc += RD_LAT + 3;
      end else begin
        cyc += RD_LAT + 2;
      end
    end
    return cyc + 1;
  endfunction

  function automatic int exp_count();
    return (exp_q.size() > 255) ? 255 : exp_q.size();
  endfunction

  task automatic fill_mem(input int max_area);
    for (int i = 0; i < 256; i++) begin
      area_mem[i] = LOC_W'($urandom_range(0, max_area));
      x_mem[i]    = $urandom;
      y_mem[i]    = $urandom;
    end
  endtask

  // Driver: pulse frame_done, then sample once per cycle on the falling edge until one cycle after done.
  task automatic run_scan(input logic [LBL_W-1:0] n, input int stall_first, input bit rand_ready,
                          input int fd_at, input int budget);
    int   stall_left;
    bit   prev_stall, seen_done;
    rec_t rec_now, hold_rec;
    logic [LBL_W-1:0] hold_id;
    stall_left = stall_first;
    prev_stall = 0;
    seen_done  = 0;
    hold_rec   = '0;
    hold_id    = '0;
    obs_q.delete();
    sc_done_at = 0; sc_busy = 0; sc_done_cnt = 0; sc_valid = 0; sc_stall = 0;
    sc_timeout = 1; sc_hold_bad = 0; sc_idle_after = 0;
    @(negedge clk);
    num_labels = n;
    frame_done = 1'b1;
    rpt_ready  = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      frame_done = (c == fd_at);
      if (c == 1) num_labels = LBL_W'($urandom);
      if (seen_done) begin
        sc_idle_after = (busy === 1'b0) && (done === 1'b0);
        sc_timeout = 0;
        break;
      end
      if (busy) sc_busy++;
      if (done) begin
        sc_done_cnt++;
        sc_done_at = c;
        seen_done  = 1;
      end
      if (rpt_valid) begin
        sc_valid++;
        rec_now = {rpt_id, rpt_area, rpt_x, rpt_y};
        if (prev_stall && (rec_now !== hold_rec || obj_id !== hold_id)) sc_hold_bad = 1;
        if (stall_left > 0) begin
          rpt_ready = 1'b0;
          stall_left--;
        end else if (rand_ready) begin
          rpt_ready = ($urandom_range(0, 3) != 0);
        end else begin
          rpt_ready = 1'b1;
        end
        if (rpt_ready) obs_q.push_back(rec_now);
        else sc_stall++;
        prev_stall = !rpt_ready;
        hold_rec   = rec_now;
        hold_id    = obj_id;
      end else begin
        if (prev_stall) sc_hold_bad = 1;
        prev_stall = 0;
        rpt_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    frame_done = 1'b0;
    rpt_ready  = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({obj_id, rpt_valid, rpt_id, rpt_area, rpt_x, rpt_y, busy, done, rpt_count, overrun} !== '0) begin
      failures++;
      $display("FAIL reset_values got obj_id=%0d valid=%b id=%0d area=%0d busy=%b done=%b cnt=%0d ovr=%b required all zero",
               obj_id, rpt_valid, rpt_id, rpt_area, busy, done, rpt_count, overrun);
    end
  endtask

  task automatic test_full_report();
    int exp_done;
    fill_mem(1000);
    area_mem[1] = 10; area_mem[2] = 0; area_mem[3] = 50;
    min_area = 5;
    exp_done = model_scan(3);
    run_scan(3, 0, 0, 0, 200);
    checks++;
    if (sc_timeout) begin failures++; $display("FAIL full_timeout got no done required done"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL full_nrec got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL full_rec%0d got=%h required=%h", i, (i < obs_q.size()) ? obs_q[i] : rec_t'(0), exp_q[i]);
      end
    end
    checks++;
    if (sc_done_at != exp_done) begin failures++; $display("FAIL full_done_at got=%0d required=%0d", sc_done_at, exp_done); end
    checks++;
    if (rpt_count !== LBL_W'(exp_count())) begin failures++; $display("FAIL full_count got=%0d required=%0d", rpt_count, exp_count()); end
    checks++;
    if (sc_done_cnt != 1 || !sc_idle_after) begin
      failures++; $display("FAIL full_done_pulse got pulses=%0d idle_after=%b required 1/1", sc_done_cnt, sc_idle_after);
    end
  endtask

  task automatic test_empty_frame();
    run_scan(0, 0, 0, 0, 20);
    checks++;
    if (sc_timeout || sc_done_at != 1) begin
      failures++; $display("FAIL empty_done_at got=%0d timeout=%b required=1", sc_done_at, sc_timeout);
    end
    checks++;
    if (sc_valid != 0) begin failures++; $display("FAIL empty_valid got=%0d cycles required=0", sc_valid); end
    checks++;
    if (sc_busy != 1) begin failures++; $display("FAIL empty_busy got=%0d cycles required=1", sc_busy); end
    checks++;
    if (rpt_count !== '0) begin failures++; $display("FAIL empty_count got=%0d required=0", rpt_count); end
  endtask

  task automatic test_backpressure();
    int exp_done;
    fill_mem(1000);
    area_mem[1] = 10; area_mem[2] = 0; area_mem[3] = 50;
    min_area = 5;
    exp_done = model_scan(3);
    run_scan(3, 7, 0, 0, 200);
    checks++;
    if (sc_hold_bad) begin failures++; $display("FAIL bp_hold got=changed required=stable"); end
    checks++;
    if (sc_stall != 7) begin failures++; $display("FAIL bp_stall got=%0d required=7", sc_stall); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL bp_nrec got=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_rec%0d got=%h required=%h", i, (i < obs_q.size()) ? obs_q[i] : rec_t'(0), exp_q[i]);
      end
    end
    checks++;
    if (sc_timeout || sc_done_at != exp_done + 7) begin
      failures++; $display("FAIL bp_done_at got=%0d required=%0d", sc_done_at, exp_done + 7);
    end
  endtask

  task automatic test_random();
    int n, exp_done;
    for (int it = 0; it < 4; it++) begin
      fill_mem(2000);
      min_area = LOC_W'($urandom_range(0, 2000));
      n = $urandom_range(1, 24);
      area_mem[$urandom_range(1, n)] = min_area;
      if (min_area != 0) area_mem[$urandom_range(1, n)] = min_area - 1;
      exp_done = model_scan(n);
      run_scan(LBL_W'(n), 0, 1, 0, 2000);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++; $display("FAIL rand%0d_nrec got=%0d required=%0d", it, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand%0d_rec%0d got=%h required=%h", it, i, (i < obs_q.size()) ? obs_q[i] : rec_t'(0), exp_q[i]);
        end
      end
      checks++;
      if (sc_timeout || sc_hold_bad || sc_done_at != exp_done + sc_stall) begin
        failures++;
        $display("FAIL rand%0d_timing got done_at=%0d hold_bad=%b required done_at=%0d hold_bad=0",
                 it, sc_done_at, sc_hold_bad, exp_done + sc_stall);
      end
      checks++;
      if (rpt_count !== LBL_W'(exp_count())) begin
        failures++; $display("FAIL rand%0d_count got=%0d required=%0d", it, rpt_count, exp_count());
      end
    end
  endtask

  task automatic test_last_label();
    int exp_done;
    fill_mem(100000);
    min_area = 0;
    exp_done = model_scan(255);
    run_scan(8'd255, 0, 0, 0, 4000);
    checks++;
    if (sc_timeout || sc_done_at != exp_done) begin
      failures++; $display("FAIL max_done_at got=%0d timeout=%b required=%0d", sc_done_at, sc_timeout, exp_done);
    end
    checks++;
    if (obs_q.size() != 255 || obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL max_nrec got=%0d required=%0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        if (obs_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL max_rec%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
          break;
        end
      end
    end
    checks++;
    if (rpt_count !== 8'd255) begin failures++; $display("FAIL max_count got=%0d required=255", rpt_count); end
  endtask

  task automatic test_overrun();
    int exp_done;
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_pre got=%b required=0", overrun); end
    fill_mem(1000);
    area_mem[1] = 10; area_mem[2] = 0; area_mem[3] = 50;
    min_area = 5;
    exp_done = model_scan(3);
    run_scan(3, 0, 0, 2, 200);
    checks++;
    if (sc_timeout || sc_done_at != exp_done || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ovr_scan got done_at=%0d nrec=%0d required done_at=%0d nrec=%0d",
               sc_done_at, obs_q.size(), exp_done, exp_q.size());
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (overrun !== 1'b1 || busy !== 1'b0) begin
        failures++; $display("FAIL ovr_sticky%0d got ovr=%b busy=%b required ovr=1 busy=0", k, overrun, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_send();
    bit got_valid;
    int exp_done;
    fill_mem(1000);
    area_mem[1] = 10; area_mem[2] = 0; area_mem[3] = 50;
    min_area = 5;
    got_valid = 0;
    @(negedge clk);
    num_labels = 3;
    frame_done = 1'b1;
    rpt_ready  = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      frame_done = 1'b0;
      if (rpt_valid) begin got_valid = 1; break; end
    end
    checks++;
    if (!got_valid) begin failures++; $display("FAIL rst_send_reach got=no valid required=valid"); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({obj_id, rpt_valid, rpt_id, rpt_area, rpt_x, rpt_y, busy, done, rpt_count, overrun} !== '0) begin
      failures++;
      $display("FAIL rst_send_values got obj_id=%0d valid=%b id=%0d busy=%b cnt=%0d ovr=%b required all zero",
               obj_id, rpt_valid, rpt_id, busy, rpt_count, overrun);
    end
    reset = 1'b0;
    rpt_ready = 1'b1;
    exp_done = model_scan(3);
    run_scan(3, 0, 0, 0, 200);
    checks++;
    if (sc_timeout || sc_done_at != exp_done || obs_q.size() != exp_q.size() ||
        (obs_q.size() > 0 && obs_q[0] !== exp_q[0])) begin
      failures++;
      $display("FAIL rst_rescan got done_at=%0d nrec=%0d required done_at=%0d nrec=%0d first_id=1",
               sc_done_at, obs_q.size(), exp_done, exp_q.size());
    end
  endtask

  initial begin
    reset      = 1'b1;
    frame_done = 1'b0;
    num_labels = '0;
    min_area   = '0;
    rpt_ready  = 1'b1;
    fill_mem(1000);
    test_reset();
    test_full_report();
    test_empty_frame();
    test_backpressure();
    test_random();
    test_last_label();
    test_overrun();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
